// File: rtl/pfiform_pkg.sv
// Shared defaults and helpers for the pfiform element-granular repacking FIFO.
// Holds the lane/width defaults, a constant clog2, and the lane mask builder.
package pfiform_pkg;

  localparam int ELEM_W_DEF = 6;
  localparam int LANES_DEF  = 16;
  localparam int DEPTH_DEF  = 64;
  localparam int MAX_LANES  = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bit i is set when lane i carries one of the first cnt elements.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned cnt);
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/pfiform_ring.sv
// Circular element store: writes up to LANES elements at a base index and
// presents LANES consecutive elements starting at the read base.
module pfiform_ring
  import pfiform_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = clog2(LANES),
  parameter int PTR_W  = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_base,
  input  logic [CNT_W:0]          wr_cnt,
  input  logic [LANES*ELEM_W-1:0] wr_data,
  input  logic [PTR_W-1:0]        rd_base,
  output logic [LANES*ELEM_W-1:0] rd_data
);

  logic [ELEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if ((CNT_W+1)'(i) < wr_cnt)
          mem[wr_base + PTR_W'(i)] <= wr_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

  // Index arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data[i*ELEM_W +: ELEM_W] = mem[rd_base + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/pfiform_gen.sv
// Join/pop repacking FIFO: variable elements in per beat, variable elements
// out per beat through a single registered output beat with ready/valid.
module pfiform_gen
  import pfiform_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = clog2(LANES)
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rstn,
  input  logic                      i_flush,
  input  logic                      i_join_en,
  output logic                      o_join_permit,
  input  logic [CNT_W-1:0]          i_join_amt,
  input  logic [LANES*ELEM_W-1:0]   i_join_data,
  input  logic [CNT_W-1:0]          i_pop_amt,
  input  logic                      i_drain,
  input  logic                      i_pop_permit,
  output logic                      o_pop_en,
  output logic [LANES*ELEM_W-1:0]   o_pop_data,
  output logic [CNT_W:0]            o_pop_cnt,
  output logic [clog2(DEPTH):0]     o_fill
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int BUS_W  = LANES * ELEM_W;
  localparam logic [FILL_W-1:0] PERMIT_MAX = FILL_W'(DEPTH - LANES);

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [FILL_W-1:0]    fill;
  logic                 join_fire;
  logic                 reg_free;
  logic                 has_full;
  logic                 load;
  logic [CNT_W:0]       join_cnt;
  logic [CNT_W:0]       need;
  logic [CNT_W:0]       take;
  logic [MAX_LANES-1:0] mask;
  logic [BUS_W-1:0]     rd_data;
  logic [BUS_W-1:0]     load_data;

  logic                 vld_p0;
  logic [BUS_W-1:0]     pop_data_p0;
  logic [CNT_W:0]       pop_cnt_p0;

  // Permit looks only at registered fill so it never depends on the join amount.
  assign o_join_permit = (fill <= PERMIT_MAX);
  assign join_fire     = i_join_en & o_join_permit & ~i_flush;
  assign join_cnt      = {1'b0, i_join_amt} + (CNT_W+1)'(1);
  assign need          = {1'b0, i_pop_amt} + (CNT_W+1)'(1);
  assign has_full      = (fill >= FILL_W'(need));
  assign reg_free      = ~vld_p0 | i_pop_permit;
  assign load          = reg_free & (has_full | (i_drain & (|fill)));
  assign take          = has_full ? need : fill[CNT_W:0];
  assign mask          = lane_mask(32'(take));

  generate
    if (LANES < MAX_LANES) begin : g_mask_hi
      logic mask_hi_unused;
      assign mask_hi_unused = ^mask[MAX_LANES-1:LANES];
    end
  endgenerate

  always_comb begin
    load_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) load_data[i*ELEM_W +: ELEM_W] = rd_data[i*ELEM_W +: ELEM_W];
    end
  end

  pfiform_ring #(
    .ELEM_W (ELEM_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .PTR_W  (PTR_W)
  ) u_ring (
    .clk     (i_core_clk),
    .wr_en   (join_fire),
    .wr_base (wr_ptr),
    .wr_cnt  (join_cnt),
    .wr_data (i_join_data),
    .rd_base (rd_ptr),
    .rd_data (rd_data)
  );

  // Output stage p0: one beat captured from the ring read port.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      vld_p0      <= 1'b0;
      pop_data_p0 <= '0;
      pop_cnt_p0  <= '0;
    end else if (i_flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      vld_p0      <= 1'b0;
      pop_data_p0 <= '0;
      pop_cnt_p0  <= '0;
    end else begin
      if (join_fire) wr_ptr <= wr_ptr + PTR_W'(join_cnt);
      if (load) begin
        rd_ptr      <= rd_ptr + PTR_W'(take);
        vld_p0      <= 1'b1;
        pop_data_p0 <= load_data;
        pop_cnt_p0  <= take;
      end else if (vld_p0 & i_pop_permit) begin
        vld_p0 <= 1'b0;
      end
      fill <= fill + (join_fire ? FILL_W'(join_cnt) : '0) - (load ? FILL_W'(take) : '0);
    end
  end

  assign o_pop_en   = vld_p0;
  assign o_pop_data = pop_data_p0;
  assign o_pop_cnt  = pop_cnt_p0;
  assign o_fill     = fill;

endmodule
